// File: rtl/uart_xyz_frame_ctrl_pkg.sv
// Shared constants/types for the x/y/z frame sequencer.
// State encodings, error codes, SOF default, hex ranges; UART_FRAME_CHKSUM_EN adds ST_CHK.
package uart_xyz_frame_ctrl_pkg;

  localparam logic [7:0] SOF_DEF     = 8'h24;
  localparam int         DIGITS_DEF  = 24;
  localparam int         TIMEOUT_DEF = 20000;
  localparam int         TO_W_DEF    = 15;

  localparam logic [1:0] ERR_RX  = 2'd0;
  localparam logic [1:0] ERR_ILL = 2'd1;
  localparam logic [1:0] ERR_TO  = 2'd2;
  localparam logic [1:0] ERR_CHK = 2'd3;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_UA = 8'h41;
  localparam logic [7:0] CH_UF = 8'h46;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_LF = 8'h66;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_WAIT_CONV = 3'd2,
`ifdef UART_FRAME_CHKSUM_EN
    ST_CHK       = 3'd3,
`endif
    ST_ABORT     = 3'd4
  } state_t;

endpackage

// File: rtl/uart_xyz_frame_ctrl_if.sv
// Handshake bundle between uart_rx, frame sequencer and x/y/z converter.
// slave: sequencer side (rx_* and conv_valid in); master: surrounding logic.
interface uart_xyz_frame_ctrl_if;
  import uart_xyz_frame_ctrl_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_dataerror;
  logic       rx_frameerror;
  logic       conv_valid;
  logic [7:0] conv_asc;
  logic       conv_start;
  logic       conv_clr;
  logic       frame_valid;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  modport slave (
    input  rx_data, rx_valid,
    input  rx_dataerror, rx_frameerror,
    input  conv_valid,
    output conv_asc, conv_start, conv_clr,
    output frame_valid, frame_err,
    output err_code, busy
  );

  modport master (
    output rx_data, rx_valid,
    output rx_dataerror, rx_frameerror,
    output conv_valid,
    input  conv_asc, conv_start, conv_clr,
    input  frame_valid, frame_err,
    input  err_code, busy
  );

endinterface

// File: rtl/uart_xyz_frame_ctrl_hex_char_check.sv
// Combinational hex-ASCII classifier: ch in, is_hex + nibble value out.
// Ports: ch[7:0] in; is_hex, nib[3:0] out (nib 0 when not hex).
module uart_hex_char_check
  import uart_xyz_frame_ctrl_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] nib
);

  logic dig;
  logic up;
  logic lo;

  always_comb begin
    dig    = (ch >= CH_0) && (ch <= CH_9);
    up     = (ch >= CH_UA) && (ch <= CH_UF);
    lo     = (ch >= CH_LA) && (ch <= CH_LF);
    is_hex = dig | up | lo;
    nib    = 4'h0;
    // 'A'/'a' low nibble is 1, so +9 gives 10..15
    unique case (1'b1)
      dig:     nib = ch[3:0];
      up, lo:  nib = ch[3:0] + 4'd9;
      default: nib = 4'h0;
    endcase
  end

endmodule

// File: rtl/uart_xyz_frame_ctrl.sv
// Frame sequencer: SOF sync, forwards DIGITS hex chars to converter, reports good frame/error.
// Ports: clk, rst_n (async low), bus (slave). Macro UART_FRAME_CHKSUM_EN adds XOR checksum check.
module uart_xyz_frame_ctrl
  import uart_xyz_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] SOF_CHAR    = SOF_DEF,
  parameter int         DIGITS      = DIGITS_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int         TO_W        = TO_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  uart_xyz_frame_ctrl_if.slave bus
);

  localparam logic [4:0]      LAST   = 5'(DIGITS - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  state_t          state;
  logic [4:0]      count;
  logic [TO_W-1:0] timer;

  logic       is_hex;
  logic [3:0] nib;
  logic       rx_bad;
  logic       rx_ok;
  logic       rx_sof;
  logic       rx_hex;
  logic       rx_ill;
  logic       to_hit;
  logic       in_scan;
  logic       abt;
  logic [1:0] abt_code;

`ifdef UART_FRAME_CHKSUM_EN
  logic [3:0] hi;
  logic [7:0] acc;
  logic       chk_bad;
`else
  // nibble value only feeds the checksum path
  logic unused_nib;
  assign unused_nib = ^nib;
`endif

  uart_hex_char_check u_hex (
    .ch     (bus.rx_data),
    .is_hex (is_hex),
    .nib    (nib)
  );

  assign rx_bad = bus.rx_valid
                & (bus.rx_dataerror | bus.rx_frameerror);
  assign rx_ok  = bus.rx_valid & ~rx_bad;
  assign rx_sof = rx_ok & (bus.rx_data == SOF_CHAR);
  assign rx_hex = rx_ok & is_hex & ~rx_sof;
  assign rx_ill = rx_ok & ~is_hex & ~rx_sof;
  // an arriving byte beats a simultaneous expiry
  assign to_hit = (timer == TO_MAX) & ~bus.rx_valid;

`ifdef UART_FRAME_CHKSUM_EN
  assign in_scan = (state == ST_COLLECT)
                 | (state == ST_CHK);
  assign chk_bad = (state == ST_CHK) & rx_hex & count[0]
                 & ({hi, nib} != acc);
`else
  assign in_scan = (state == ST_COLLECT);
`endif

  always_comb begin
    abt      = 1'b0;
    abt_code = ERR_RX;
    if (in_scan) begin
      unique case (1'b1)
        rx_bad: begin
          abt      = 1'b1;
          abt_code = ERR_RX;
        end
        rx_ill: begin
          abt      = 1'b1;
          abt_code = ERR_ILL;
        end
        to_hit: begin
          abt      = 1'b1;
          abt_code = ERR_TO;
        end
`ifdef UART_FRAME_CHKSUM_EN
        chk_bad: begin
          abt      = 1'b1;
          abt_code = ERR_CHK;
        end
`endif
        default: ;
      endcase
    end else if (state == ST_WAIT_CONV) begin
      if ((timer == TO_MAX) && !bus.conv_valid) begin
        abt      = 1'b1;
        abt_code = ERR_TO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      count           <= '0;
      timer           <= '0;
      bus.conv_asc    <= '0;
      bus.conv_start  <= 1'b0;
      bus.conv_clr    <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.err_code    <= ERR_RX;
      bus.busy        <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
      hi              <= '0;
      acc             <= '0;
`endif
    end else begin
      bus.conv_start  <= 1'b0;
      bus.conv_clr    <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      if (timer != '1)
        timer <= timer + TO_W'(1);
      if (abt) begin
        // pulses line up with the one-cycle ABORT state
        state         <= ST_ABORT;
        bus.frame_err <= 1'b1;
        bus.conv_clr  <= 1'b1;
        bus.err_code  <= abt_code;
        count         <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            timer <= '0;
            if (rx_sof) begin
              bus.conv_clr <= 1'b1;
              bus.busy     <= 1'b1;
              count        <= '0;
              state        <= ST_COLLECT;
`ifdef UART_FRAME_CHKSUM_EN
              acc          <= '0;
`endif
            end
          end
          ST_COLLECT: begin
            if (rx_sof) begin
              bus.conv_clr <= 1'b1;
              count        <= '0;
              timer        <= '0;
`ifdef UART_FRAME_CHKSUM_EN
              acc          <= '0;
`endif
            end else if (rx_hex) begin
              bus.conv_asc   <= bus.rx_data;
              bus.conv_start <= 1'b1;
              count          <= count + 5'd1;
              timer          <= '0;
`ifdef UART_FRAME_CHKSUM_EN
              if (!count[0])
                hi  <= nib;
              else
                acc <= acc ^ {hi, nib};
              if (count == LAST)
                state <= ST_CHK;
`else
              if (count == LAST)
                state <= ST_WAIT_CONV;
`endif
            end
          end
`ifdef UART_FRAME_CHKSUM_EN
          ST_CHK: begin
            if (rx_sof) begin
              bus.conv_clr <= 1'b1;
              count        <= '0;
              timer        <= '0;
              acc          <= '0;
              state        <= ST_COLLECT;
            end else if (rx_hex) begin
              timer <= '0;
              // count parity continues: even = hi char, odd = lo char
              if (!count[0]) begin
                hi    <= nib;
                count <= count + 5'd1;
              end else begin
                state <= ST_WAIT_CONV;
              end
            end
          end
`endif
          ST_WAIT_CONV: begin
            if (bus.conv_valid) begin
              bus.frame_valid <= 1'b1;
              bus.busy        <= 1'b0;
              count           <= '0;
              state           <= ST_IDLE;
            end
          end
          ST_ABORT: begin
            bus.busy <= 1'b0;
            timer    <= '0;
            state    <= ST_IDLE;
          end
          default: begin
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_xyz_frame_ctrl.sv
// Directed bench for uart_xyz_frame_ctrl with a behavioural x/y/z converter.
// Define UART_FRAME_CHKSUM_EN to exercise checksum framing.
module tb_uart_xyz_frame_ctrl;
  import uart_xyz_frame_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_xyz_frame_ctrl_if bus ();

  uart_xyz_frame_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [95:0] sr;
  int nd;
  int n_start = 0;
  int n_fv = 0;
  int n_fe = 0;
  int n_clr = 0;
  int s0, v0, e0, c0;

  string ck1, ck2, ck3, ck4;

  function automatic logic [3:0] hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return 4'(c - 8'd48);
    if (c >= "A" && c <= "F") return 4'(c - 8'd55);
    if (c >= "a" && c <= "f") return 4'(c - 8'd87);
    return 4'h0;
  endfunction

  // converter model: shifts one nibble per start, valid after 24
  always @(negedge clk) begin
    if (!rst_n) begin
      sr <= '0;
      nd <= 0;
      bus.conv_valid <= 1'b0;
    end else begin
      if (bus.conv_start) begin
        n_start <= n_start + 1;
        sr <= {sr[91:0], hexval(bus.conv_asc)};
        nd <= nd + 1;
        if (nd == 23) bus.conv_valid <= 1'b1;
      end
      if (bus.conv_clr) begin
        n_clr <= n_clr + 1;
        sr <= '0;
        nd <= 0;
        bus.conv_valid <= 1'b0;
      end
      if (bus.frame_valid) n_fv <= n_fv + 1;
      if (bus.frame_err) n_fe <= n_fe + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] c,
                      input logic fe = 1'b0);
    @(negedge clk);
    bus.rx_data = c;
    bus.rx_valid = 1'b1;
    bus.rx_frameerror = fe;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_frameerror = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic snap();
    s0 = n_start; v0 = n_fv; e0 = n_fe; c0 = n_clr;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (bus.busy && k < max) begin
      @(negedge clk);
      k++;
    end
    check("idle_in_time", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
`ifdef UART_FRAME_CHKSUM_EN
    ck1 = "17"; ck2 = "00"; ck3 = "08"; ck4 = "88";
`else
    ck1 = ""; ck2 = ""; ck3 = ""; ck4 = "";
`endif
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_dataerror = 1'b0;
    bus.rx_frameerror = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_fv", 32'(bus.frame_valid), 0);
    check("rst_fe", 32'(bus.frame_err), 0);
    check("rst_code", 32'(bus.err_code), 0);
    check("rst_start", 32'(bus.conv_start), 0);
    check("rst_clr", 32'(bus.conv_clr), 0);
    check("rst_asc", 32'(bus.conv_asc), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // good frame
    snap();
    send("$");
    send_str({"0000000A00000014FFFFFFF6", ck1});
    wait_idle(200);
    check("t1_starts", n_start - s0, 24);
    check("t1_fv", n_fv - v0, 1);
    check("t1_fe", n_fe - e0, 0);
    check("t1_x", sr[95:64], 32'h0000000A);
    check("t1_y", sr[63:32], 32'h00000014);
    check("t1_z", sr[31:0], 32'hFFFFFFF6);

    // junk in IDLE ignored
    snap();
    send("A");
    send("Z");
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_starts", n_start - s0, 0);

    // illegal char
    snap();
    send("$");
    send_str("0123456789G");
    wait_idle(50);
    check("t2_fe", n_fe - e0, 1);
    check("t2_code", 32'(bus.err_code), 1);
    check("t2_clr", n_clr - c0, 2);
    check("t2_fv", n_fv - v0, 0);

    // reset mid-frame
    snap();
    send("$");
    send_str("123");
    rst_n = 1'b0;
    #1;
    check("rstm_busy", 32'(bus.busy), 0);
    check("rstm_code", 32'(bus.err_code), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rstm_fe", n_fe - e0, 0);
    check("rstm_fv", n_fv - v0, 0);

    // timeout, then a good frame
    snap();
    send("$");
    send_str("12345");
    repeat (19900) @(negedge clk);
    check("t3_early", 32'(bus.busy), 1);
    wait_idle(1000);
    check("t3_fe", n_fe - e0, 1);
    check("t3_code", 32'(bus.err_code), 2);
    snap();
    send("$");
    send_str({"000000010000000200000003", ck2});
    wait_idle(200);
    check("t3_fv", n_fv - v0, 1);
    check("t3_x", sr[95:64], 32'h1);
    check("t3_y", sr[63:32], 32'h2);
    check("t3_z", sr[31:0], 32'h3);

    // rx frame error
    snap();
    send("$");
    send_str("0123456");
    send("5", 1'b1);
    wait_idle(50);
    check("t4_fe", n_fe - e0, 1);
    check("t4_code", 32'(bus.err_code), 0);
    snap();
    send("$");
    send_str({"123456781234567812345678", ck3});
    wait_idle(200);
    check("t4_fv", n_fv - v0, 1);
    check("t4_x", sr[95:64], 32'h12345678);
    check("t4_y", sr[63:32], 32'h12345678);
    check("t4_z", sr[31:0], 32'h12345678);

    // restart on SOF inside frame
    snap();
    send("$");
    send_str("1234$");
    send_str({"ABCDEF01abcdef01ABCDEF01", ck4});
    wait_idle(200);
    check("t5_fv", n_fv - v0, 1);
    check("t5_fe", n_fe - e0, 0);
    check("t5_clr", n_clr - c0, 2);
    check("t5_starts", n_start - s0, 28);
    check("t5_x", sr[95:64], 32'hABCDEF01);
    check("t5_y", sr[63:32], 32'hABCDEF01);
    check("t5_z", sr[31:0], 32'hABCDEF01);

`ifdef UART_FRAME_CHKSUM_EN
    snap();
    send("$");
    send_str("01010101010101010101010100");
    wait_idle(200);
    check("ck_fv", n_fv - v0, 1);
    snap();
    send("$");
    send_str("01010101010101010101010101");
    wait_idle(200);
    check("ck_fe", n_fe - e0, 1);
    check("ck_code", 32'(bus.err_code), 3);
    check("ck_nofv", n_fv - v0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
